griffin_li_sched: RTL and testbench

//  Sequences the Griffin linear-combination stage L_i = (i-1)*y0 + y1 + x_i over branches i = 2..T-1.
//  Per job: latches y0/y1, reads x_i from the permutation state register file, and issues one branch per cycle into the pipelined Li datapath.

---
 rtl/griffin_pkg.sv | 23 ++
 rtl/griffin_sync_fifo.sv | 63 ++++++
 rtl/griffin_li_sched.sv | 215 +++++++++++++++++++++
 tb/tb_griffin_li_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/griffin_pkg.sv
// griffin_pkg: shared types and constants for the Griffin Li scheduler.
// Holds the FSM encoding, default field width and branch index width.
package griffin_pkg;

    localparam int N_BITS_DEF = 254;
    localparam int IDX_W      = 5;

    localparam logic [255:0] PRIME_MODULUS =
        256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } li_sched_state_e;

    function automatic logic [IDX_W-1:0] next_idx(
        input logic [IDX_W-1:0] i
    );
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/griffin_sync_fifo.sv
// griffin_sync_fifo: single-clock FIFO with occupancy count output.
// Head entry is presented combinationally while the FIFO is not empty.
module griffin_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Storage write; data words need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The scheduler's credit scheme must never push into a full buffer.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full)
    );

endmodule

// File: rtl/griffin_li_sched.sv
// griffin_li_sched: issues Griffin L_i branches into the Li datapath and
// streams results in index order. Perf counters: GRIFFIN_LI_SCHED_PERF_EN.
module griffin_li_sched
    import griffin_pkg::*;
#(
    parameter int N_BITS     = N_BITS_DEF,
    parameter int STATE_T    = 12,
    parameter int LI_LATENCY = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [N_BITS-1:0] y0,
    input  logic [N_BITS-1:0] y1,
    output logic              x_rd_en,
    output logic [IDX_W-1:0]  x_rd_addr,
    input  logic [N_BITS-1:0] x_rd_data,
    output logic              li_valid,
    output logic [IDX_W-1:0]  li_i,
    output logic [N_BITS-1:0] li_y0,
    output logic [N_BITS-1:0] li_y1,
    output logic [N_BITS-1:0] li_x,
    input  logic [N_BITS-1:0] li_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [N_BITS-1:0] out_l,
`ifdef GRIFFIN_LI_SCHED_PERF_EN
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = IDX_W + N_BITS;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STATE_T - 1);

    li_sched_state_e state_q;
    li_sched_state_e state_d;

    logic [IDX_W-1:0]  idx_q;
    logic [N_BITS-1:0] y0_q;
    logic [N_BITS-1:0] y1_q;
    logic              li_valid_q;
    logic [IDX_W-1:0]  li_idx_q;
    logic              dl_v   [LI_LATENCY];
    logic [IDX_W-1:0]  dl_idx [LI_LATENCY];
    logic [IDX_W-1:0]  in_flight_q;

    logic              accept;
    logic              issue;
    logic              has_credit;
    logic              push;
    logic              pop;
    logic [EW-1:0]     push_data;
    logic [EW-1:0]     head;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    int unsigned       used;

    // Credit: slots not yet claimed by the FIFO or by reads in flight.
    always_comb begin
        used       = 32'(fifo_count) + 32'(in_flight_q);
        has_credit = (used < 32'(FIFO_DEPTH));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, handshake and issue decisions.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        accept      = 1'b0;
        issue       = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (has_credit) begin
                    issue = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (in_flight_q == '0 &&
                    fifo_count == CW'(1) && pop) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Job operands and branch index counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q  <= '0;
            y1_q  <= '0;
            idx_q <= FIRST_IDX;
        end else if (accept) begin
            y0_q  <= y0;
            y1_q  <= y1;
            idx_q <= FIRST_IDX;
        end else if (issue) begin
            idx_q <= next_idx(idx_q);
        end
    end

    // Issue stage: read data arrives one cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            li_valid_q <= 1'b0;
            li_idx_q   <= FIRST_IDX;
        end else begin
            li_valid_q <= issue;
            if (issue) begin
                li_idx_q <= idx_q;
            end
        end
    end

    // Valid/index delay line matching the Li datapath depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LI_LATENCY; k++) begin
                dl_v[k]   <= 1'b0;
                dl_idx[k] <= '0;
            end
        end else begin
            dl_v[0]   <= li_valid_q;
            dl_idx[0] <= li_idx_q;
            for (int k = 1; k < LI_LATENCY; k++) begin
                dl_v[k]   <= dl_v[k-1];
                dl_idx[k] <= dl_idx[k-1];
            end
        end
    end

    // Reads issued but not yet landed in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_q + IDX_W'(issue) - IDX_W'(push);
        end
    end

    assign push      = dl_v[LI_LATENCY-1];
    assign push_data = {dl_idx[LI_LATENCY-1], li_result};
    assign pop       = out_valid && out_ready;

    griffin_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign x_rd_en   = issue;
    assign x_rd_addr = idx_q;
    assign li_valid  = li_valid_q;
    assign li_i      = li_idx_q - 1'b1;
    assign li_y0     = y0_q;
    assign li_y1     = y1_q;
    assign li_x      = x_rd_data;
    assign out_valid = !fifo_empty;
    assign out_idx   = head[N_BITS +: IDX_W];
    assign out_l     = head[N_BITS-1:0];

`ifdef GRIFFIN_LI_SCHED_PERF_EN
    // Saturating busy and credit-stall cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state_q != IDLE && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 1'b1;
            end
            if (state_q == RUN && !has_credit &&
                perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_griffin_li_sched.sv
// tb_griffin_li_sched: randomized scoreboard bench for griffin_li_sched.
// Models the x register file and the Li datapath around the scheduler.
module tb_griffin_li_sched;

    localparam int NB    = 254;
    localparam int ST    = 12;
    localparam int LAT   = 3;
    localparam int FD    = 4;
    localparam int NBEAT = ST - 2;

    typedef logic [NB-1:0] fe_t;

    typedef struct {
        logic [4:0] idx;
        fe_t        l;
        bit         last;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    fe_t        y0;
    fe_t        y1;
    logic       x_rd_en;
    logic [4:0] x_rd_addr;
    fe_t        x_rd_data;
    logic       li_valid;
    logic [4:0] li_i;
    fe_t        li_y0;
    fe_t        li_y1;
    fe_t        li_x;
    fe_t        li_result;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_idx;
    fe_t        out_l;
    logic       done;
`ifdef GRIFFIN_LI_SCHED_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    griffin_li_sched #(
        .N_BITS     (NB),
        .STATE_T    (ST),
        .LI_LATENCY (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .y0          (y0),
        .y1          (y1),
        .x_rd_en     (x_rd_en),
        .x_rd_addr   (x_rd_addr),
        .x_rd_data   (x_rd_data),
        .li_valid    (li_valid),
        .li_i        (li_i),
        .li_y0       (li_y0),
        .li_y1       (li_y1),
        .li_x        (li_x),
        .li_result   (li_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_l       (out_l),
`ifdef GRIFFIN_LI_SCHED_PERF_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .done        (done)
    );

    beat_t exp_q[$];
    fe_t   xmem [32];
    fe_t   pipe [LAT];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_jobs = 0;
    int    done_cnt = 0;
    int    xrd_cnt = 0;
    int    cyc = 0;
    int    last_xrd_cyc = 0;
    int    done_cyc = 0;
    int    rdy_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input fe_t act, input fe_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // State register file: data valid the cycle after the read strobe.
    initial begin
        logic       en;
        logic [4:0] addr;
        x_rd_data = '0;
        forever begin
            @(negedge clk);
            en   = x_rd_en;
            addr = x_rd_addr;
            @(posedge clk);
            #1;
            if (en) x_rd_data = xmem[addr];
        end
    end

    // Free-running Li datapath, LAT cycles deep.
    for (genvar g = 0; g < LAT; g++) begin : g_pipe_init
        initial pipe[g] = '0;
    end
    assign li_result = pipe[LAT-1];

    initial begin
        fe_t v;
        forever begin
            @(negedge clk);
            v = fe_t'(li_i) * li_y0 + li_y1 + li_x;
            @(posedge clk);
            #1;
            for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = v;
        end
    end

    // Consumer ready pattern.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expectations on each accepted beat.
    initial begin
        bit         hold_prev = 0;
        bit         done_prev = 0;
        logic [4:0] prev_idx = '0;
        fe_t        prev_l = '0;
        beat_t      b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold_prev = 0;
                done_prev = 0;
            end else begin
                if (x_rd_en) begin
                    xrd_cnt++;
                    last_xrd_cyc = cyc;
                end
                if (done_prev) chk("start_ready_after_done", fe_t'(start_ready), 1);
                if (hold_prev) begin
                    chk("hold_valid", fe_t'(out_valid), 1);
                    chk("hold_idx", fe_t'(out_idx), fe_t'(prev_idx));
                    chk("hold_l", out_l, prev_l);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_beat: got idx %0d expected none", out_idx);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_idx", fe_t'(out_idx), fe_t'(b.idx));
                        chk("beat_l", out_l, b.l);
                        chk("done_on_last", fe_t'(done), fe_t'(b.last));
                    end
                end else begin
                    chk("done_no_pop", fe_t'(done), 0);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                done_prev = done;
                hold_prev = out_valid && !out_ready;
                prev_idx  = out_idx;
                prev_l    = out_l;
            end
        end
    end

    // Offer a job; on acceptance queue its expected results.
    task automatic start_job(input fe_t a, input fe_t b);
        int t = 0;
        beat_t e;
        for (int i = 2; i < ST; i++) xmem[i] = fe_t'({$urandom, $urandom});
        @(posedge clk);
        #1;
        while (!start_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (!start_ready) begin
            n_err++;
            $display("FAIL start_timeout: got ready 0 expected 1");
            return;
        end
        start_valid = 1'b1;
        y0 = a;
        y1 = b;
        for (int i = 2; i < ST; i++) begin
            e.idx  = 5'(i);
            e.l    = fe_t'(i - 1) * a + b + xmem[i];
            e.last = (i == ST - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int t = 0;
        while (done_cnt <= base && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (done_cnt <= base) begin
            n_err++;
            $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, base + 1);
        end
    endtask

    function automatic fe_t rnd();
        return fe_t'({$urandom, $urandom});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, x0, c0, c1, cret, t;
`ifdef GRIFFIN_LI_SCHED_PERF_EN
        logic [31:0] pb0, ps0;
`endif
        rst_n = 1'b0;
        start_valid = 1'b0;
        y0 = '0;
        y1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", fe_t'(start_ready), 1);
        chk("rst_out_valid", fe_t'(out_valid), 0);
        chk("rst_x_rd_en", fe_t'(x_rd_en), 0);
        chk("rst_li_valid", fe_t'(li_valid), 0);
        chk("rst_done", fe_t'(done), 0);
        rst_n = 1'b1;

        // Small operands, free-flowing consumer, first-result latency.
        rdy_mode = 0;
        base = done_cnt;
        start_job(5, 7);
        n_jobs++;
        c0 = -1;
        c1 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (x_rd_en && c0 < 0) c0 = k;
            if (out_valid) begin
                c1 = k;
                break;
            end
        end
        chk("first_latency", fe_t'(c1 - c0), LAT + 2);
        wait_done(base);

        // Blocked consumer: issue stops once the FIFO credit is used up.
        rdy_mode = 1;
        base = done_cnt;
        x0 = xrd_cnt;
        start_job(rnd(), rnd());
        n_jobs++;
        cret = cyc;
`ifdef GRIFFIN_LI_SCHED_PERF_EN
        pb0 = perf_busy_cycles;
        ps0 = perf_stall_cycles;
`endif
        repeat (20) begin
            @(negedge clk);
            #1;
        end
        chk("blocked_issues", fe_t'(xrd_cnt - x0), FD);
        rdy_mode = 0;
        wait_done(base);
        chk("total_issues", fe_t'(xrd_cnt - x0), NBEAT);
`ifdef GRIFFIN_LI_SCHED_PERF_EN
        @(posedge clk);
        #1;
        chk("perf_busy", fe_t'(perf_busy_cycles - pb0), fe_t'(done_cyc - cret));
        chk("perf_stall", fe_t'(perf_stall_cycles - ps0),
            fe_t'(last_xrd_cyc - cret - NBEAT));
`endif

        // Back-to-back jobs with different y0.
        base = done_cnt;
        start_job(1, rnd());
        n_jobs++;
        wait_done(base);
        base = done_cnt;
        start_job(2, rnd());
        n_jobs++;
        wait_done(base);

        // start_valid during a running job must be ignored.
        base = done_cnt;
        start_job(3, 11);
        n_jobs++;
        repeat (2) @(posedge clk);
        #1;
        start_valid = 1'b1;
        y0 = 99;
        y1 = 99;
        repeat (3) @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_done(base);

        // Reset with reads in flight: aborted results never appear.
        rdy_mode = 0;
        x0 = xrd_cnt;
        start_job(rnd(), rnd());
        t = 0;
        while (xrd_cnt - x0 < 2 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("abort_out_valid", fe_t'(out_valid), 0);
        chk("abort_start_ready", fe_t'(start_ready), 1);
        chk("abort_x_rd_en", fe_t'(x_rd_en), 0);
        chk("abort_done", fe_t'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random jobs under random backpressure.
        for (int j = 0; j < 8; j++) begin
            rdy_mode = (j % 3 == 0) ? 0 : 2;
            base = done_cnt;
            start_job(rnd(), rnd());
            n_jobs++;
            wait_done(base);
        end

        rdy_mode = 0;
        repeat (10) @(negedge clk);
        chk("queue_drained", fe_t'(exp_q.size()), 0);
        chk("done_count", fe_t'(done_cnt), fe_t'(n_jobs));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
